seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Reader side of the 7-segment display path: samples a 7-segment pattern from pads and recovers the displayed digit.
- Used to observe an external or looped-back counter display.
- Synchronizes and debounces the segment bus, decodes stable patterns to a 4-bit value, and flags illegal patterns.
- Classifies each accepted change as up-step, down-step or skip, mirroring the up/down wrap counter that drives the display.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted; legal range 1..255.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  raw segment pattern, bit0=a ... bit6=g, active high, asynchronous to clk
digit  output  4  last successfully decoded value
digit_valid  output  1  level: digit reflects the currently accepted pattern
bad_pattern  output  1  level: currently accepted pattern is not in the decode table
new_digit  output  1  one-cycle pulse: a new valid digit was accepted
step_up  output  1  one-cycle pulse: new digit = previous + 1 (mod N)
step_down  output  1  one-cycle pulse: new digit = previous - 1 (mod N)
step_skip  output  1  one-cycle pulse: new digit differs from previous by any other amount

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low, and clears every flop, including the synchronizer.
- Reset values: digit=0; digit_valid=0; bad_pattern=0; all pulses 0; candidate=0; count=0; accepted pattern=0; history invalid.
- Synchronizer: 2-flop synchronizer on seg_in; seg_s is the second stage.
- Candidate and count:
  - If seg_s != candidate: load candidate from seg_s, count=1.
  - Else if count < STABLE_CYCLES: count+1.
  - count saturates at STABLE_CYCLES.
- Stable event: fires on the edge where count becomes STABLE_CYCLES, including the load edge when STABLE_CYCLES=1. It fires once per candidate.
- Latency: if k is the first edge whose sync1 captures the new pattern, outputs update at edge k+1+STABLE_CYCLES. With the default, that is 5 edges.
- On a stable event where candidate == accepted pattern: no output change and no pulses. This is how glitches that return to the old pattern are filtered.
- On a stable event where candidate != accepted pattern, accepted pattern <= candidate, then:
  - 0x00 (blank): digit_valid=0, bad_pattern=0, digit held, history cleared, no pulses.
  - Decodable: digit=value, digit_valid=1, bad_pattern=0, new_digit=1.
    - If history is valid, exactly one of step_up, step_down or step_skip pulses, comparing against the history digit.
    - If history is invalid, no step pulse.
    - History is then set to this digit.
  - Other patterns: bad_pattern=1, digit_valid=0, digit held, history cleared, no pulses.
- Decode table: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. N=10.
- Wrap: 9->0 is step_up; 0->9 is step_down.
- Pulses are registered, exactly one cycle wide, and coincident with the digit update.
- Reset mid-debounce discards the candidate. The first accepted digit after reset never produces a step pulse.

Optional Feature:
- Macro: SEG7_CAPTURE_HEX_EN.
- Defined:
  - Also decodes A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - N=16: 9->A is step_up; F->0 is step_up; 0->F is step_down; 9->0 is step_skip.
- Undefined:
  - Those six patterns set bad_pattern.
  - N=10 as above.

Test Plan:
- Reset, then hold seg_in=0x5B: digit=2, digit_valid=1 and new_digit pulse at edge 5 after first sampling; no step pulse.
- Sequence 0x5B->0x4F->0x66, each held 10 cycles: digits 3 and 4 each with one new_digit and one step_up. Then 0x4F: step_down, digit=3.
- 0x6F (9) then 0x3F (0): step_up (wrap). 0x3F then 0x6F: step_down. 0x06 (1) then 0x66 (4): step_skip.
- Holding 0x06, apply 0x5B for 3 cycles then return to 0x06: no pulses, digit stays 1. A 0x5B pulse of exactly 4 cycles is accepted (digit=2).
- Apply 0x77 without the macro: bad_pattern=1, digit_valid=0, digit holds last value. Then 0x3F: new_digit, no step pulse. Apply 0x00: digit_valid=0, bad_pattern=0.
- Assert rst_n low for 1 cycle mid-count with 0x7F applied: all outputs 0 immediately. After release, 0x7F is accepted after 5 edges with no step pulse.

Source files
------------

// File: rtl/seg7_capture.sv
// Samples a 7-segment pad bus, debounces it and decodes the displayed digit with step classification.
// Optional hex decode (A..F, modulo-16 stepping) is enabled by defining SEG7_CAPTURE_HEX_EN.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       bad_pattern,
    output logic       new_digit,
    output logic       step_up,
    output logic       step_down,
    output logic       step_skip
);

`ifdef SEG7_CAPTURE_HEX_EN
    localparam int unsigned N_DIGITS = 16;
`else
    localparam int unsigned N_DIGITS = 10;
`endif
    localparam logic [3:0] MAX_DIGIT = 4'(N_DIGITS - 1);
    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [6:0] r_sync1;
    logic [6:0] r_seg_s;
    logic [6:0] r_cand;
    logic [7:0] r_count;
    logic [6:0] r_acc;
    logic       r_hist_valid;
    logic [3:0] r_hist;

    logic       w_diff;
    logic [7:0] w_next_count;
    logic       w_stable;
    logic [4:0] w_dec;
    logic [3:0] w_hist_inc;
    logic [3:0] w_hist_dec;

    // Returns {legal, value}; blank and unknown patterns return legal=0.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h6F:   return {1'b1, 4'd9};
`ifdef SEG7_CAPTURE_HEX_EN
            7'h77:   return {1'b1, 4'd10};
            7'h7C:   return {1'b1, 4'd11};
            7'h39:   return {1'b1, 4'd12};
            7'h5E:   return {1'b1, 4'd13};
            7'h79:   return {1'b1, 4'd14};
            7'h71:   return {1'b1, 4'd15};
`endif
            default: return 5'd0;
        endcase
    endfunction

    assign w_diff       = (r_seg_s != r_cand);
    assign w_next_count = w_diff ? 8'd1 : ((r_count < STABLE_CNT) ? r_count + 8'd1 : r_count);
    // Fires once per candidate: the edge where the count first reaches the threshold.
    assign w_stable     = (w_next_count == STABLE_CNT) && (w_diff || (r_count != STABLE_CNT));
    assign w_dec        = f_decode(r_seg_s);
    assign w_hist_inc   = (r_hist == MAX_DIGIT) ? 4'd0 : r_hist + 4'd1;
    assign w_hist_dec   = (r_hist == 4'd0) ? MAX_DIGIT : r_hist - 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= '0;
            r_seg_s      <= '0;
            r_cand       <= '0;
            r_count      <= '0;
            r_acc        <= '0;
            r_hist_valid <= 1'b0;
            r_hist       <= '0;
            digit        <= '0;
            digit_valid  <= 1'b0;
            bad_pattern  <= 1'b0;
            new_digit    <= 1'b0;
            step_up      <= 1'b0;
            step_down    <= 1'b0;
            step_skip    <= 1'b0;
        end else begin
            r_sync1   <= seg_in;
            r_seg_s   <= r_sync1;
            r_cand    <= r_seg_s;
            r_count   <= w_next_count;
            new_digit <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            step_skip <= 1'b0;
            if (w_stable && (r_seg_s != r_acc)) begin
                r_acc <= r_seg_s;
                if (r_seg_s == 7'h00) begin
                    digit_valid  <= 1'b0;
                    bad_pattern  <= 1'b0;
                    r_hist_valid <= 1'b0;
                end else if (w_dec[4]) begin
                    digit        <= w_dec[3:0];
                    digit_valid  <= 1'b1;
                    bad_pattern  <= 1'b0;
                    new_digit    <= 1'b1;
                    r_hist_valid <= 1'b1;
                    r_hist       <= w_dec[3:0];
                    if (r_hist_valid) begin
                        step_up   <= (w_dec[3:0] == w_hist_inc);
                        step_down <= (w_dec[3:0] == w_hist_dec);
                        step_skip <= (w_dec[3:0] != w_hist_inc) && (w_dec[3:0] != w_hist_dec);
                    end
                end else begin
                    digit_valid  <= 1'b0;
                    bad_pattern  <= 1'b1;
                    r_hist_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: segment runs are modelled as held patterns, expected events queued with their due cycle.
// Honours SEG7_CAPTURE_HEX_EN for the reference decode table.
module tb_seg7_capture;

    localparam int SC = 4;
`ifdef SEG7_CAPTURE_HEX_EN
    localparam int NDIG = 16;
`else
    localparam int NDIG = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip;

    seg7_capture #(.STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit),
        .digit_valid(digit_valid), .bad_pattern(bad_pattern), .new_digit(new_digit),
        .step_up(step_up), .step_down(step_down), .step_skip(step_skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] outs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   started = 0;

    logic [6:0] seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state
    int m_acc, m_digit, m_valid, m_bad, m_hist_v, m_hist;
    int run_pat, run_start, run_len, run_done;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_decode(input int pat);
        for (int i = 0; i < NDIG; i++)
            if (int'(seg_tab[i]) == pat) return i;
        return -1;
    endfunction

    task automatic push_event(input int k, input int nd, input int up, input int dn, input int sk);
        exp_t e;
        e.cyc  = k + 1 + SC;
        e.outs = {4'(m_digit), 1'(m_valid), 1'(m_bad), 1'(nd), 1'(up), 1'(dn), 1'(sk)};
        q.push_back(e);
    endtask

    task automatic model_accept(input int pat, input int k);
        int v, d;
        if (pat == m_acc) return;
        m_acc = pat;
        v = ref_decode(pat);
        if (pat == 0) begin
            if (m_valid || m_bad) begin
                m_valid = 0; m_bad = 0;
                push_event(k, 0, 0, 0, 0);
            end
            m_hist_v = 0;
        end else if (v >= 0) begin
            m_digit = v; m_valid = 1; m_bad = 0;
            if (m_hist_v) begin
                d = (v - m_hist + NDIG) % NDIG;
                push_event(k, 1, int'(d == 1), int'(d == NDIG - 1), int'(d != 1 && d != NDIG - 1));
            end else begin
                push_event(k, 1, 0, 0, 0);
            end
            m_hist_v = 1; m_hist = v;
        end else begin
            if (!m_bad) begin
                m_bad = 1; m_valid = 0;
                push_event(k, 0, 0, 0, 0);
            end
            m_hist_v = 0;
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_digit = 0; m_valid = 0; m_bad = 0; m_hist_v = 0; m_hist = 0;
    endtask

    // Called at a negedge: drives pat for len cycles; the next posedge is the first one that samples it.
    task automatic apply(input int pat, input int len);
        seg_in = 7'(pat);
        if (pat != run_pat) begin
            run_pat = pat; run_start = cyc + 1; run_len = 0; run_done = 0;
        end
        run_len += len;
        if (!run_done && run_len >= SC) begin
            run_done = 1;
            model_accept(pat, run_start);
        end
        repeat (len) @(negedge clk);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_clear: got %b want 0", {digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_pat = -1;
    endtask

    // Monitor: any pulse or level change of digit_valid/bad_pattern is an observable event.
    logic pv = 1'b0, pb = 1'b0;
    always @(negedge clk) begin
        if (rst_n && started) begin
            if (new_digit || step_up || step_down || step_skip || digit_valid != pv || bad_pattern != pb) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d got %b want none", cyc,
                             {digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip});
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.outs !== {digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip}
                        || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL event: cycle %0d got %b, want cycle %0d value %b", cyc,
                                 {digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip},
                                 e.cyc, e.outs);
                    end
                end
            end
            pv = digit_valid;
            pb = bad_pattern;
        end else begin
            pv = 1'b0;
            pb = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] hex_tab[6] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    initial begin
        int sel, pat, prev;
        rst_n  = 1'b0;
        seg_in = 7'h00;
        model_reset();
        run_pat = 0; run_start = 0; run_len = SC; run_done = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0", {digit, digit_valid, bad_pattern, new_digit, step_up, step_down, step_skip});
        end
        rst_n = 1'b1;
        started = 1;

        apply('h5B, 10); apply('h4F, 10); apply('h66, 10); apply('h4F, 10);
        apply('h6F, 10); apply('h3F, 10); apply('h6F, 10);
        apply('h06, 10); apply('h66, 10); apply('h06, 10);
        apply('h5B, 3);  apply('h06, 10);
        apply('h5B, 4);  apply('h06, 10);
        apply('h77, 10); apply('h3F, 10); apply('h00, 10);
        apply('h06, 10); apply('h00, 1);  apply('h06, 10);
        apply('h7F, 2);
        reset_mid();
        apply('h7F, 10);

        prev = 'h7F;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3, 4: pat = int'(seg_tab[$urandom_range(0, NDIG - 1)]);
                5:             pat = int'(seg_tab[$urandom_range(0, 9)]);
                6:             pat = int'(hex_tab[$urandom_range(0, 5)]);
                7:             pat = 0;
                8:             pat = int'($urandom_range(0, 127));
                default:       pat = prev;
            endcase
            prev = pat;
            apply(pat, int'($urandom_range(1, 12)));
        end
        apply('h3F, 20);
        repeat (20) @(negedge clk);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
